// File: rtl/dmem_hs_pkg.sv
// dmem_hs shared types and default parameters.
// State encoding and default geometry of the handshaked data memory.
package dmem_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 2;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/dmem_hs_array.sv
// dmem_hs storage: DEPTH x DATA_W words, byte-enable write port.
// Read is combinational from the same word index as the write.
module dmem_hs_array
    import dmem_hs_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int BE_W  = DATA_W / 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write; contents are never touched by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_hs.sv
// dmem_hs: valid/ready data memory with fixed response latency.
// Define DMEM_HS_ERR_CHECK_EN to flag misaligned/out-of-range accesses.
module dmem_hs
    import dmem_hs_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    state_e state;
    state_e state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic              q_we;
    logic [ADDR_W-1:0] q_addr;
    logic [DATA_W-1:0] q_wdata;
    logic [BE_W-1:0]   q_be;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              accept;
    logic              acc_fire;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic              acc_err;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] arr_rdata;

    assign accept = (state == IDLE) && req_valid;

    // With zero latency the access happens on the accepting edge
    // straight from the request inputs; otherwise at the end of WAIT.
    assign acc_fire = (accept && (LATENCY == 0)) ||
                      ((state == WAIT) && (cnt == '0));

    assign acc_we    = (state == IDLE) ? req_we    : q_we;
    assign acc_addr  = (state == IDLE) ? req_addr  : q_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : q_wdata;
    assign acc_be    = (state == IDLE) ? req_be    : q_be;
    assign acc_idx   = acc_addr[OFF_W +: IDX_W];

`ifdef DMEM_HS_ERR_CHECK_EN
    logic [63:0] acc_widx;
    assign acc_widx = 64'(acc_addr) >> OFF_W;
    assign acc_err  = (acc_addr[OFF_W-1:0] != '0) ||
                      (acc_widx >= 64'(DEPTH));
`else
    logic unused_addr;
    assign unused_addr = ^acc_addr;
    assign acc_err     = 1'b0;
`endif

    dmem_hs_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (acc_fire && acc_we && !acc_err),
        .addr  (acc_idx),
        .wdata (acc_wdata),
        .be    (acc_be),
        .rdata (arr_rdata)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs follow the state directly.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE:    req_ready = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Wait counter: loaded on acceptance, counts down through WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_INIT;
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Request capture on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_we    <= 1'b0;
            q_addr  <= '0;
            q_wdata <= '0;
            q_be    <= '0;
        end else if (accept) begin
            q_we    <= req_we;
            q_addr  <= req_addr;
            q_wdata <= req_wdata;
            q_be    <= req_be;
        end
    end

    // Response capture at the access cycle, held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (acc_fire) begin
            rdata_q <= (acc_we || acc_err) ? '0 : arr_rdata;
            err_q   <= acc_err;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
